// File: rtl/uart_rx_oversampled_if.sv
// Receive-side handshake bundle: the received byte, its valid/ready pair and the
// two error pulses. The receiver drives it through the master modport and the
// consumer through the slave modport.
interface uart_rx_oversampled_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 overrun;

  modport master (output rx_data, rx_valid, frame_err, overrun, input rx_ready);
  modport slave  (input rx_data, rx_valid, frame_err, overrun, output rx_ready);
endinterface

// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver driven by a 16x sample-enable pulse.
// Start-bit qualification, 3-sample majority vote at mid-bit, framing-error and
// break handling, and a single-entry holding register with overrun reporting.
module uart_rx_oversampled #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clk_smp,
  input  logic rxd,
  uart_rx_oversampled_if.master rx
);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [3:0]       LAST_TICK = 4'(OVERSAMPLE - 1);
  localparam logic [3:0]       VOTE_TICK = 4'(OVERSAMPLE / 2 + 1);
  localparam logic [3:0]       SMP_FIRST = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK_WAIT} state_t;

  state_t               state, state_n;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 rxs;
  logic [3:0]           smp_cnt, cnt_n, tick;
  logic [IDX_W-1:0]     bit_idx, idx_n;
  // Samples from ticks 7 and 8; the tick-9 sample is the live rxs value, so
  // the three-sample window needs only two stored bits.
  logic [1:0]           samp_sh, samp_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 vote;
  logic                 byte_done;
  logic                 stop_bad;

  assign rxs = sync_q[SYNC_STAGES-1];

  // Metastability synchroniser for the asynchronous pin; idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '1;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
  end

  // FSM and datapath state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      smp_cnt <= '0;
      bit_idx <= '0;
      samp_sh <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_n;
      smp_cnt <= cnt_n;
      bit_idx <= idx_n;
      samp_sh <= samp_n;
      shreg   <= shreg_n;
    end
  end

  // Next-state logic: smp_cnt holds the index of the last tick seen, so the
  // current tick is smp_cnt+1; the 4-bit wrap from 15 starts the next bit at 0.
  always_comb begin
    state_n   = state;
    cnt_n     = smp_cnt;
    idx_n     = bit_idx;
    samp_n    = samp_sh;
    shreg_n   = shreg;
    byte_done = 1'b0;
    stop_bad  = 1'b0;
    tick      = smp_cnt + 4'd1;
    vote      = (samp_sh[1] & samp_sh[0]) | (samp_sh[1] & rxs) | (samp_sh[0] & rxs);
    if (clk_smp) begin
      if (state == START || state == DATA || state == STOP) begin
        cnt_n = tick;
        if (tick >= SMP_FIRST && tick < VOTE_TICK) samp_n = {samp_sh[0], rxs};
      end
      unique case (state)
        IDLE: begin
          if (!rxs) begin
            state_n = START;
            cnt_n   = '0;
          end
        end
        START: begin
          if (tick == VOTE_TICK && vote) begin
            state_n = IDLE;
          end else if (tick == LAST_TICK) begin
            state_n = DATA;
            idx_n   = '0;
          end
        end
        DATA: begin
          if (tick == VOTE_TICK) shreg_n = {vote, shreg[DATA_BITS-1:1]};
          if (tick == LAST_TICK) begin
            if (bit_idx == LAST_IDX) state_n = STOP;
            else                     idx_n   = bit_idx + 1'b1;
          end
        end
        STOP: begin
          if (tick == VOTE_TICK) begin
            if (vote) begin
              byte_done = 1'b1;
              state_n   = IDLE;
            end else begin
              stop_bad  = 1'b1;
              state_n   = BRK_WAIT;
            end
          end
        end
        BRK_WAIT: begin
          if (rxs) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Holding register: accept a new byte if empty or being drained this cycle,
  // otherwise drop it and flag overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx.rx_data   <= '0;
      rx.rx_valid  <= 1'b0;
      rx.frame_err <= 1'b0;
      rx.overrun   <= 1'b0;
    end else begin
      rx.frame_err <= stop_bad;
      rx.overrun   <= 1'b0;
      if (byte_done) begin
        if (!rx.rx_valid || rx.rx_ready) begin
          rx.rx_data  <= shreg;
          rx.rx_valid <= 1'b1;
        end else begin
          rx.overrun  <= 1'b1;
        end
      end else if (rx.rx_valid && rx.rx_ready) begin
        rx.rx_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled: 50 MHz clock, 16x tick for ~115200 bps.
module tb_uart_rx_oversampled;
  localparam int DIV = 27;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic clk_smp = 1'b0;
  logic rxd     = 1'b1;
  int   div_cnt = 0;

  int checks = 0;
  int errors = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  int both_cnt = 0;
  logic [7:0] acc_q[$];

  uart_rx_oversampled_if #(.DATA_BITS(8)) rx_if ();

  uart_rx_oversampled #(.DATA_BITS(8), .OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .clk_smp(clk_smp), .rxd(rxd), .rx(rx_if)
  );

  always #10 clk = ~clk;

  // 16x tick generator: one-clk pulse every DIV clocks.
  always @(posedge clk) begin
    if (div_cnt == DIV - 1) begin
      div_cnt <= 0;
      clk_smp <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 1;
      clk_smp <= 1'b0;
    end
  end

  // Consumer-side monitor using pre-edge values.
  always @(posedge clk) begin
    if (rx_if.frame_err) ferr_cnt++;
    if (rx_if.overrun) ovr_cnt++;
    if (rx_if.frame_err && rx_if.overrun) both_cnt++;
    if (rx_if.rx_valid && rx_if.rx_ready) acc_q.push_back(rx_if.rx_data);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do @(negedge clk); while (!clk_smp);
    end
  endtask

  task automatic send_head(input logic [7:0] b);
    rxd = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      wait_ticks(16);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_head(b);
    rxd = stop;
    wait_ticks(16);
  endtask

  initial begin
    rx_if.rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(rx_if.rx_valid), 0);
    check("rst_data", 32'(rx_if.rx_data), 0);
    check("rst_ferr", 32'(rx_if.frame_err), 0);
    check("rst_ovr", 32'(rx_if.overrun), 0);
    rst_n = 1'b1;
    wait_ticks(20);

    // Two back-to-back frames, consumer always ready.
    send_byte(8'h55, 1'b1); wait_ticks(32);
    send_byte(8'hA3, 1'b1); wait_ticks(32);
    check("s1_count", acc_q.size(), 2);
    check("s1_byte0", 32'(acc_q[0]), 32'h55);
    check("s1_byte1", 32'(acc_q[1]), 32'hA3);
    check("s1_ferr", ferr_cnt, 0);
    check("s1_ovr", ovr_cnt, 0);
    check("s1_valid_low", 32'(rx_if.rx_valid), 0);

    // Short low glitch must be rejected, then a normal frame follows.
    rxd = 1'b0; wait_ticks(4); rxd = 1'b1; wait_ticks(32);
    check("glitch_count", acc_q.size(), 2);
    check("glitch_ferr", ferr_cnt, 0);
    send_byte(8'h3C, 1'b1); wait_ticks(32);
    check("s2_count", acc_q.size(), 3);
    check("s2_byte", 32'(acc_q[2]), 32'h3C);

    // Bad stop bit followed by a held-low break, then recovery.
    send_byte(8'hA5, 1'b0);
    wait_ticks(48);
    rxd = 1'b1; wait_ticks(32);
    check("brk_ferr", ferr_cnt, 1);
    check("brk_count", acc_q.size(), 3);
    send_byte(8'h7E, 1'b1); wait_ticks(32);
    check("s3_count", acc_q.size(), 4);
    check("s3_byte", 32'(acc_q[3]), 32'h7E);
    check("s3_ferr", ferr_cnt, 1);

    // Consumer stalled: first byte held, second dropped with overrun.
    rx_if.rx_ready = 1'b0;
    send_head(8'h12);
    rxd = 1'b1;
    wait_ticks(10);
    check("lat_before", 32'(rx_if.rx_valid), 0);
    @(negedge clk);
    check("lat_valid", 32'(rx_if.rx_valid), 1);
    check("lat_data", 32'(rx_if.rx_data), 32'h12);
    wait_ticks(6); wait_ticks(32);
    send_byte(8'h34, 1'b1); wait_ticks(32);
    check("ovr_data", 32'(rx_if.rx_data), 32'h12);
    check("ovr_valid", 32'(rx_if.rx_valid), 1);
    check("ovr_cnt", ovr_cnt, 1);
    check("ovr_ferr", ferr_cnt, 1);
    rx_if.rx_ready = 1'b1;
    @(negedge clk);
    rx_if.rx_ready = 1'b0;
    @(negedge clk);
    check("drain_valid", 32'(rx_if.rx_valid), 0);
    check("drain_count", acc_q.size(), 5);
    check("drain_byte", 32'(acc_q[4]), 32'h12);

    // Accept in the exact completion cycle of the next byte: no overrun.
    send_byte(8'h12, 1'b1); wait_ticks(32);
    check("same_pend_valid", 32'(rx_if.rx_valid), 1);
    check("same_pend_data", 32'(rx_if.rx_data), 32'h12);
    send_head(8'h34);
    rxd = 1'b1;
    wait_ticks(10);
    rx_if.rx_ready = 1'b1;
    @(negedge clk);
    rx_if.rx_ready = 1'b0;
    check("same_valid", 32'(rx_if.rx_valid), 1);
    check("same_data", 32'(rx_if.rx_data), 32'h34);
    check("same_ovr", ovr_cnt, 1);
    check("same_count", acc_q.size(), 6);
    check("same_byte", 32'(acc_q[5]), 32'h12);
    wait_ticks(6); wait_ticks(32);
    rx_if.rx_ready = 1'b1;
    @(negedge clk);
    check("same_drain_count", acc_q.size(), 7);
    check("same_drain_byte", 32'(acc_q[6]), 32'h34);
    @(negedge clk);
    check("same_drain_valid", 32'(rx_if.rx_valid), 0);

    // Reset during data bit 4 of 0xF0 (bits 0..3 zero, bit 4 one).
    rxd = 1'b0; wait_ticks(16);
    wait_ticks(64);
    rxd = 1'b1; wait_ticks(8);
    rst_n = 1'b0;
    #1;
    check("mid_rst_data", 32'(rx_if.rx_data), 0);
    check("mid_rst_valid", 32'(rx_if.rx_valid), 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    wait_ticks(48);
    check("mid_rst_count", acc_q.size(), 7);
    send_byte(8'h0F, 1'b1); wait_ticks(32);
    check("post_rst_count", acc_q.size(), 8);
    check("post_rst_byte", 32'(acc_q[7]), 32'h0F);
    check("final_ferr", ferr_cnt, 1);
    check("final_ovr", ovr_cnt, 1);
    check("err_ovr_exclusive", both_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_oversampled.md
Name: uart_rx_oversampled

Overview:
UART receiver that consumes the 16x sample-enable pulse (clk_smp) from the baud generator and deserialises an 8N1 frame from the rxd pin. It sits between the board RX pin and the command/debug logic. Core features:
- start-bit qualification and 3-sample majority vote per bit
- framing-error detection
- a single-entry output register with a valid/ready handshake and overrun reporting

Parameters:
DATA_BITS, 8, data bits per frame (LSB first; supported range 5..8)
OVERSAMPLE, 16, clk_smp ticks per bit period; fixed at 16, sample points assume it
SYNC_STAGES, 2, flip-flops in the rxd synchroniser (minimum 2)

Ports:
clk  in  1  system clock (50 MHz)
rst_n  in  1  reset: asynchronous, active-low
clk_smp  in  1  one-clk-wide enable pulse at 16x baud; all bit timing advances only on this pulse
rxd  in  1  asynchronous serial input, idle high
rx_data  out  DATA_BITS  received byte, stable while rx_valid=1
rx_valid  out  1  byte available; held until accepted
rx_ready  in  1  consumer accepts byte when rx_valid & rx_ready on a clk edge
frame_err  out  1  one-clk pulse: stop bit sampled 0
overrun  out  1  one-clk pulse: completed byte dropped because holding register full

Behaviour:
- Reset values: rx_data=0, rx_valid=0, frame_err=0, overrun=0, sync chain all 1, state=IDLE, smp_cnt=0, bit_idx=0.
- rxd passes through SYNC_STAGES flops clocked every clk; rxs is the last stage. All decisions use rxs.
- Timing counters change only on clk cycles with clk_smp=1. With no clk_smp pulse, the FSM holds state.
- smp_cnt is 4 bits and counts ticks within the current bit. Each bit is sampled at ticks 7, 8 and 9 into a 3-bit shift; vote = majority of the 3.
- IDLE: on a tick with rxs=0 -> START, smp_cnt=0 (that tick is tick 0).
- START:
  - At tick 9, if vote=1 -> IDLE (glitch rejected, no outputs).
  - At tick 15 -> DATA, smp_cnt=0, bit_idx=0.
- DATA:
  - At tick 9, the vote is shifted into the shift register MSB side, so LSB arrives first.
  - At tick 15: bit_idx+1, smp_cnt=0.
  - After bit_idx reaches DATA_BITS-1 at tick 15 -> STOP.
- STOP: decided at tick 9.
  - vote=1: byte complete -> IDLE (early exit so the next start edge is caught from mid-stop-bit onward).
  - vote=0: frame_err pulses on the next clk, byte discarded -> BRK_WAIT.
- BRK_WAIT: stays until a tick with rxs=1 -> IDLE. This prevents break conditions from producing repeated frames.
- Byte delivery (on the clk edge after the STOP tick-9 decision):
  - if rx_valid=0, or rx_valid & rx_ready in that same cycle: rx_data<=new byte, rx_valid<=1.
  - else: overrun pulses 1 clk, rx_data keeps the old byte, the new byte is dropped.
- Handshake: rx_valid & rx_ready with no completing byte -> rx_valid<=0 next clk; rx_data is unchanged (don't-care to consumer).
- Latency: rx_valid rises 1 clk after the clk_smp pulse at stop-bit tick 9. rxd-to-sampling delay is SYNC_STAGES clks.
- Line-rate jitter: a start edge is accepted anywhere in IDLE. Tolerance is about ±3 ticks cumulative drift over the frame.
- frame_err and overrun never assert in the same cycle. A framing error does not affect rx_valid/rx_data.
- rst_n asserted mid-frame: everything returns to reset values immediately. A partial byte is never delivered.

Test Plan:
- 115200 bps, clk_smp from a 16x generator, send 0x55 then 0xA3 with rx_ready=1 -> rx_valid pulses twice, rx_data=0x55 then 0xA3, no frame_err/overrun.
- rxd low for 4 ticks then high (glitch) -> FSM returns to IDLE at tick 9; no rx_valid, no frame_err; a following 0x3C frame is received correctly.
- Send 0xA5 with stop bit driven 0, then hold rxd low 3 bit times, then 0x7E -> frame_err one pulse, 0xA5 not delivered, rxd held low gives no further frames, 0x7E delivered.
- rx_ready=0, send 0x12 then 0x34 -> rx_data=0x12 held, rx_valid=1, overrun one pulse at 0x34 completion; after rx_ready=1 for one clk, rx_valid=0.
- rx_ready asserted exactly in the cycle 0x34 completes while 0x12 is pending -> 0x12 accepted, rx_data=0x34, rx_valid stays 1, no overrun.
- Assert rst_n low during data bit 4 of 0xF0, release, send 0x0F -> no output for 0xF0; rx_data=0x0F delivered cleanly.
